sha_1_stream_core: RTL and testbench

SHA_1_STREAM_CORE -- requirements
Module: sha_1_stream_core

---
 rtl/sha_1_stream_core_if.sv | 23 ++
 rtl/sha_1_stream_core.sv | 134 +++++++++++++
 tb/tb_sha_1_stream_core.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sha_1_stream_core_if.sv
// Block-in / digest-out handshake bundle for sha_1_stream_core.
// The producer/consumer side uses master, the core uses slave.
interface sha_1_stream_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
  logic         in_first;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [159:0] out_digest;
  logic         busy;

  modport master (
    output in_valid, in_block, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_digest, busy
  );

  modport slave (
    input  in_valid, in_block, in_first, in_last, out_ready,
    output in_ready, out_valid, out_digest, busy
  );
endinterface

// File: rtl/sha_1_stream_core.sv
// SHA-1 block engine: R rounds per clock, digest after 80/R + 1 edges from accept.
// Accepts only in IDLE; with HOLD_OUTPUT the digest waits for out_ready, otherwise it pulses.
module sha_1_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit HOLD_OUTPUT      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  sha_1_stream_core_if.slave bus
);
  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 5 || R == 8 || R == 10 || R == 16 || R == 20)) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be one of 1,2,4,5,8,10,16,20");
  end

  localparam logic [31:0] IV0 = 32'h67452301;
  localparam logic [31:0] IV1 = 32'hEFCDAB89;
  localparam logic [31:0] IV2 = 32'h98BADCFE;
  localparam logic [31:0] IV3 = 32'h10325476;
  localparam logic [31:0] IV4 = 32'hC3D2E1F0;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;

  state_t      state;
  logic [6:0]  t;
  logic [31:0] win [16];
  logic [31:0] a, b, c, d, e;
  logic [31:0] h [5];
  logic [31:0] hs [5];
  logic        last;

  logic [31:0] win_nxt [16];
  logic [31:0] a_nxt, b_nxt, c_nxt, d_nxt, e_nxt;

  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);

  assign hs[0] = h[0] + a;
  assign hs[1] = h[1] + b;
  assign hs[2] = h[2] + c;
  assign hs[3] = h[3] + d;
  assign hs[4] = h[4] + e;

  // Schedule is extended by R words so rounds beyond the 16-word window (R=20) still see W[t+j].
  always_comb begin : rounds
    logic [31:0] ext [16+R];
    logic [31:0] va, vb, vc, vd, ve, f, kc, tmp, x;
    logic [6:0]  tt;
    for (int i = 0; i < 16 + R; i++) ext[i] = '0;
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int i = 16; i < 16 + R; i++) begin
      x      = ext[i-3] ^ ext[i-8] ^ ext[i-14] ^ ext[i-16];
      ext[i] = {x[30:0], x[31]};
    end
    va = a; vb = b; vc = c; vd = d; ve = e;
    f = '0; kc = '0; tmp = '0; tt = '0; x = '0;
    for (int j = 0; j < R; j++) begin
      tt = t + 7'(j);
      if (tt < 7'd20) begin
        f  = (vb & vc) | (~vb & vd);
        kc = 32'h5A827999;
      end else if (tt < 7'd40) begin
        f  = vb ^ vc ^ vd;
        kc = 32'h6ED9EBA1;
      end else if (tt < 7'd60) begin
        f  = (vb & vc) | (vb & vd) | (vc & vd);
        kc = 32'h8F1BBCDC;
      end else begin
        f  = vb ^ vc ^ vd;
        kc = 32'hCA62C1D6;
      end
      tmp = {va[26:0], va[31:27]} + f + ve + kc + ext[j];
      ve  = vd;
      vd  = vc;
      vc  = {vb[1:0], vb[31:2]};
      vb  = va;
      va  = tmp;
    end
    for (int i = 0; i < 16; i++) win_nxt[i] = ext[i+R];
    a_nxt = va; b_nxt = vb; c_nxt = vc; d_nxt = vd; e_nxt = ve;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      t              <= '0;
      h              <= '{IV0, IV1, IV2, IV3, IV4};
      last           <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_digest <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < 16; i++) win[i] <= bus.in_block[511-32*i -: 32];
            if (bus.in_first) begin
              h <= '{IV0, IV1, IV2, IV3, IV4};
              a <= IV0; b <= IV1; c <= IV2; d <= IV3; e <= IV4;
            end else begin
              a <= h[0]; b <= h[1]; c <= h[2]; d <= h[3]; e <= h[4];
            end
            last  <= bus.in_last;
            t     <= '0;
            state <= ROUND;
          end
        end
        ROUND: begin
          win <= win_nxt;
          a <= a_nxt; b <= b_nxt; c <= c_nxt; d <= d_nxt; e <= e_nxt;
          t <= t + 7'(R);
          if (t == 7'(80 - R)) state <= FINAL;
        end
        FINAL: begin
          h <= hs;
          if (last) begin
            bus.out_digest <= {hs[0], hs[1], hs[2], hs[3], hs[4]};
            bus.out_valid  <= 1'b1;
            state          <= OUT;
          end else begin
            state <= IDLE;
          end
        end
        OUT: begin
          if (!HOLD_OUTPUT || bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha_1_stream_core.sv
// Directed-vector bench: R=1 held-output core plus one pulsed-output core per other legal R.
module tb_sha_1_stream_core;
  localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};
  localparam logic [159:0] ABC_D   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] EMPTY_D = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] TWO_D   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
  localparam int NR = 7;
  localparam int RS [NR] = '{2, 4, 5, 8, 10, 16, 20};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  sha_1_stream_core_if bus ();
  sha_1_stream_core #(.ROUNDS_PER_CYCLE(1), .HOLD_OUTPUT(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic         m_valid;
  logic [511:0] m_blk;
  logic [NR-1:0] ov;
  logic [159:0] dig [NR];

  for (genvar i = 0; i < NR; i++) begin : g_r
    sha_1_stream_core_if bus_r ();
    assign bus_r.in_valid  = m_valid;
    assign bus_r.in_block  = m_blk;
    assign bus_r.in_first  = 1'b1;
    assign bus_r.in_last   = 1'b1;
    assign bus_r.out_ready = 1'b0;
    assign ov[i]  = bus_r.out_valid;
    assign dig[i] = bus_r.out_digest;
    sha_1_stream_core #(.ROUNDS_PER_CYCLE(RS[i]), .HOLD_OUTPUT(1'b0)) dut_r (
      .clk(clk), .rst(rst), .bus(bus_r)
    );
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns edges until out_valid is seen (limit if never).
  task automatic wait_out(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (bus.out_valid) break;
    end
  endtask

  int lat [NR];
  int hi_cnt [NR];
  logic [159:0] got_d [NR];

  task automatic run_multi(input logic [511:0] blk);
    for (int i = 0; i < NR; i++) begin
      lat[i] = 0; hi_cnt[i] = 0; got_d[i] = '0;
    end
    m_blk = blk;
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (ov[i]) begin
          hi_cnt[i]++;
          if (lat[i] == 0) begin
            lat[i] = n;
            got_d[i] = dig[i];
          end
        end
      end
    end
  endtask

  int  n;
  bit  ok, rdy, seen;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_block = '0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    m_valid = 1'b0; m_blk = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", 160'(bus.in_ready), 160'(1));
    check("rst_busy", 160'(bus.busy), 160'(0));
    check("rst_out_valid", 160'(bus.out_valid), 160'(0));
    check("rst_digest", bus.out_digest, 160'h0);

    // "abc" single block, garbage offered while busy, output held.
    bus.in_block = ABC; bus.in_first = 1'b1; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_block = ~ABC; bus.in_first = 1'b0;
    check("abc_busy", 160'(bus.busy), 160'(1));
    check("abc_in_ready_low", 160'(bus.in_ready), 160'(0));
    wait_out(200, n);
    bus.in_valid = 1'b0;
    check("abc_latency", 160'(n), 160'(81));
    check("abc_digest", bus.out_digest, ABC_D);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(bus.out_valid && bus.out_digest == ABC_D && !bus.in_ready)) ok = 1'b0;
    end
    check("hold_stable", 160'(ok), 160'(1));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("release_out_valid", 160'(bus.out_valid), 160'(0));
    check("release_in_ready", 160'(bus.in_ready), 160'(1));
    check("digest_kept", bus.out_digest, ABC_D);

    // Two-block message with in_valid held high.
    bus.in_block = B1; bus.in_first = 1'b1; bus.in_last = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_block = B2; bus.in_first = 1'b0; bus.in_last = 1'b1;
    n = 0; rdy = 1'b0;
    while (n < 200) begin
      rdy = bus.in_ready;
      tick();
      n++;
      if (rdy) break;
    end
    bus.in_valid = 1'b0;
    check("two_accept_gap", 160'(n), 160'(82));
    wait_out(200, n);
    check("two_latency", 160'(n), 160'(81));
    check("two_digest", bus.out_digest, TWO_D);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Abort "abc" at round 40; then resend with in_first=0.
    bus.in_block = ABC; bus.in_first = 1'b1; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 90; i++) begin
      if (bus.out_valid) seen = 1'b1;
      if (i == 0) begin
        check("abort_in_ready", 160'(bus.in_ready), 160'(1));
        check("abort_busy", 160'(bus.busy), 160'(0));
        check("abort_digest", bus.out_digest, 160'h0);
      end
      tick();
    end
    check("abort_no_out_valid", 160'(seen), 160'(0));
    bus.in_block = ABC; bus.in_first = 1'b0; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_out(200, n);
    check("resend_latency", 160'(n), 160'(81));
    check("resend_digest", bus.out_digest, ABC_D);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Every other legal R, pulsed output.
    run_multi(ABC);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("r%0d_latency", RS[i]), 160'(lat[i]), 160'(80 / RS[i] + 1));
      check($sformatf("r%0d_digest", RS[i]), got_d[i], ABC_D);
      check($sformatf("r%0d_pulse", RS[i]), 160'(hi_cnt[i]), 160'(1));
    end
    run_multi(EMPTY);
    check("empty_r4_latency", 160'(lat[1]), 160'(21));
    check("empty_r4_digest", got_d[1], EMPTY_D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
